bus_byte_responder: RTL

BUS_BYTE_RESPONDER -- requirements
Module: bus_byte_responder

---
 rtl/bus_byte_responder.sv | 79 +++++++
 1 files changed

// File: rtl/bus_byte_responder.sv
// bus_byte_responder: serialises a 32-bit word-bus access into byte-wide memory cycles.
module bus_byte_responder #(
    parameter int BUS_WORD_ADDR_WIDTH = 16
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Req,
    input  logic                           i_We,
    input  logic [BUS_WORD_ADDR_WIDTH-1:0] i_Addr,
    input  logic [3:0]                     i_ByteEn,
    input  logic [31:0]                    i_WD,
    output logic [31:0]                    o_RD,
    output logic                           o_Busy,
    output logic                           o_Done,
    output logic [BUS_WORD_ADDR_WIDTH+1:0] o_Mem_Addr,
    output logic [7:0]                     o_Mem_WD,
    output logic                           o_Mem_We,
    output logic                           o_Mem_Re,
    input  logic [7:0]                     i_Mem_RD
);
    typedef enum logic [2:0] {IDLE, WR_LANE, RD_ISSUE, RD_CAPTURE, DONE} state_t;
    state_t state, state_n;
    logic [BUS_WORD_ADDR_WIDTH-1:0] addr_r;
    logic [3:0] pend;
    logic [3:0] pend_next;
    logic [31:0] wd_r;
    logic [1:0] lane;
    // pending lanes are serviced lowest-first; clearing the lowest set bit advances the lane
    assign lane = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
    assign pend_next = pend & (pend - 4'd1);
    assign o_Busy = state != IDLE;
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
            o_RD <= '0;
            pend <= '0;
            addr_r <= '0;
            wd_r <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && i_Req) begin
                addr_r <= i_Addr;
                pend <= i_ByteEn;
                wd_r <= i_WD;
                if (!i_We) o_RD <= '0;
            end
            if (state == WR_LANE || state == RD_CAPTURE) pend <= pend_next;
            if (state == RD_CAPTURE) o_RD[{lane, 3'b000} +: 8] <= i_Mem_RD;
        end
    end
    always_comb begin
        state_n = state;
        o_Done = 1'b0;
        o_Mem_We = 1'b0;
        o_Mem_Re = 1'b0;
        o_Mem_Addr = '0;
        o_Mem_WD = '0;
        case (state)
            IDLE: if (i_Req) state_n = (i_ByteEn == 4'd0) ? DONE : i_We ? WR_LANE : RD_ISSUE;
            WR_LANE: begin
                o_Mem_We = 1'b1;
                o_Mem_Addr = {addr_r, lane};
                o_Mem_WD = wd_r[{lane, 3'b000} +: 8];
                state_n = (pend_next == 4'd0) ? DONE : WR_LANE;
            end
            RD_ISSUE: begin
                o_Mem_Re = 1'b1;
                o_Mem_Addr = {addr_r, lane};
                state_n = RD_CAPTURE;
            end
            RD_CAPTURE: state_n = (pend_next == 4'd0) ? DONE : RD_ISSUE;
            DONE: begin
                o_Done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
